// File: rtl/multiplier_signed_seq_pkg.sv
// rtl/multiplier_signed_seq_pkg.sv - FSM state encoding and sizing helper for the sequential signed multiplier
package multiplier_signed_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Iteration counter width; counts 0..w-1, and never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/multiplier_signed_seq_if.sv
// rtl/multiplier_signed_seq_if.sv - operand/product valid-ready bundle for the sequential signed multiplier
interface multiplier_signed_seq_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     P;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, P
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, P
  );
endinterface

// File: rtl/multiplier_signed_seq_negate_n.sv
// rtl/multiplier_signed_seq_negate_n.sv - N-bit two's-complement negate (invert and add one)
module negate_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_val,
  output logic [N-1:0] o_neg
);
  assign o_neg = ~i_val + N'(1);
endmodule

// File: rtl/multiplier_signed_seq.sv
// rtl/multiplier_signed_seq.sv - sign-magnitude shift-add WIDTHxWIDTH signed multiplier, one multiplier bit per cycle
// Define MULT_EARLY_TERM_EN to leave CALC once no set multiplier bits remain.
module multiplier_signed_seq
  import multiplier_signed_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  multiplier_signed_seq_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_p;
  logic [CW-1:0]        r_count;
  logic                 r_neg;

  logic [WIDTH-1:0]     w_a_neg;
  logic [WIDTH-1:0]     w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_acc_neg;
  logic                 w_calc_last;
  logic                 w_in_ready;
  logic                 w_out_valid;

  negate_n #(.N(WIDTH))   u_neg_a   (.i_val(bus.A), .o_neg(w_a_neg));
  negate_n #(.N(WIDTH))   u_neg_b   (.i_val(bus.B), .o_neg(w_b_neg));
  negate_n #(.N(2*WIDTH)) u_neg_acc (.i_val(r_acc), .o_neg(w_acc_neg));

  // |-2^(W-1)| wraps to 2^(W-1), which is exactly right when read as unsigned.
  assign w_a_mag = bus.A[WIDTH-1] ? w_a_neg : bus.A;
  assign w_b_mag = bus.B[WIDTH-1] ? w_b_neg : bus.B;

`ifdef MULT_EARLY_TERM_EN
  assign w_calc_last = (r_count == CW'(WIDTH-1)) || ((r_mplier >> 1) == '0);
`else
  assign w_calc_last = (r_count == CW'(WIDTH-1));
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = ST_CALC;
      end
      ST_CALC: begin
        if (w_calc_last) w_next = ST_SIGN;
      end
      ST_SIGN: begin
        w_next = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_p      <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        ST_CALC: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
        end
        ST_SIGN: begin
          r_p <= r_neg ? w_acc_neg : r_acc;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.P         = r_p;

endmodule
